// File: rtl/bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_seq
//
// Sequential packed-BCD to binary converter (reverse double-dabble).
// A conversion is accepted from IDLE on start. Each SHIFT cycle moves the
// concatenation {bcd, bin} right by one bit. Every BCD digit that then reads
// 8 or more is reduced by 3, which undoes the decimal weighting of the
// bit that crossed the digit boundary. After BIN_W shifts the binary
// register holds the result.
// An input with any digit above 9 is rejected in one cycle with err and done.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    synchronous active-low reset
//   start    conversion request, honoured only when idle
//   bcd_in   packed BCD, digit 0 in [3:0], sampled on the accepting edge
//   bin_out  converted value, held until the next completion or rejection
//   busy     high while a conversion is in flight
//   done     one-cycle completion pulse (also pulsed on rejection)
//   err      last accepted input held an invalid digit
// ---------------------------------------------------------------------------
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // True when any packed digit lies outside 0..9.
    function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bad = bad | (v[4*i +: 4] > 4'd9);
        end
        return bad;
    endfunction

    // Per-digit correction: digits of 8 or more lose 3, without borrow
    // between digits.
    function automatic logic [BCD_W-1:0] adjust_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic [3:0]       d;
        r = {BCD_W{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            r[4*i +: 4] = (d >= 4'd8) ? (d - 4'd3) : d;
        end
        return r;
    endfunction

    state_t            state_r, state_s;
    logic [BCD_W-1:0]  bcd_r, bcd_s;
    logic [BIN_W-1:0]  bin_r, bin_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [BIN_W-1:0]  bin_out_r, bin_out_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              err_r, err_s;
    logic [BCD_W-1:0]  shift_bcd_s;
    logic [BIN_W-1:0]  shift_bin_s;

    // Next-state and next-output logic for the IDLE/SHIFT controller.
    always_comb begin
        state_s   = state_r;
        bcd_s     = bcd_r;
        bin_s     = bin_r;
        cnt_s     = cnt_r;
        bin_out_s = bin_out_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        err_s     = err_r;

        // One-bit right shift of {bcd, bin}; the BCD lsb feeds the binary msb.
        shift_bcd_s = {1'b0, bcd_r[BCD_W-1:1]};
        shift_bin_s = {bcd_r[0], bin_r[BIN_W-1:1]};

        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
                if (start) begin
                    if (has_bad_digit(bcd_in)) begin
                        // Reject: report immediately, never enter SHIFT.
                        err_s     = 1'b1;
                        done_s    = 1'b1;
                        bin_out_s = {BIN_W{1'b0}};
                        busy_s    = 1'b0;
                        state_s   = ST_IDLE;
                    end else begin
                        bcd_s   = bcd_in;
                        bin_s   = {BIN_W{1'b0}};
                        cnt_s   = {CNT_W{1'b0}};
                        err_s   = 1'b0;
                        busy_s  = 1'b1;
                        state_s = ST_SHIFT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                bcd_s = adjust_digits(shift_bcd_s);
                bin_s = shift_bin_s;
                cnt_s = cnt_r + CNT_ONE;
                if (cnt_r == CNT_LAST) begin
                    // Final shift: binary register is now complete.
                    bin_out_s = shift_bin_s;
                    done_s    = 1'b1;
                    busy_s    = 1'b0;
                    state_s   = ST_IDLE;
                end else begin
                    busy_s  = 1'b1;
                    state_s = ST_SHIFT;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            bcd_r     <= {BCD_W{1'b0}};
            bin_r     <= {BIN_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            bin_out_r <= {BIN_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            bcd_r     <= bcd_s;
            bin_r     <= bin_s;
            cnt_r     <= cnt_s;
            bin_out_r <= bin_out_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            err_r     <= err_s;
        end
    end

    assign bin_out = bin_out_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_bin_seq
//
// Scoreboard bench for bcd_to_bin_seq. The driver issues requests and
// pushes the decimal value it expects (computed arithmetically from the
// digits) into a queue. A monitor pops one entry on every done pulse and
// compares the result, the err flag, the latency and the busy run length.
// ---------------------------------------------------------------------------
module tb_bcd_to_bin_seq;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [11:0]       bcd_in;
    logic [BIN_W-1:0]  bin_out;
    logic              busy;
    logic              done;
    logic              err;

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic             err;
        int               acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   ecount = 0;
    int   busy_run = 0;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges so accept and completion edges can be compared.
    always @(posedge clk) ecount <= ecount + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act === req) begin
            passes = passes + 1;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: decimal value of the digits, or rejection if any digit > 9.
    task automatic ref_model(input logic [11:0] b, output logic [BIN_W-1:0] v, output logic e);
        int acc;
        int w;
        int d;
        acc = 0;
        w   = 1;
        e   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'((b >> (4 * i)) & 12'hF);
            if (d > 9) e = 1'b1;
            acc = acc + d * w;
            w   = w * 10;
        end
        v = e ? '0 : acc[BIN_W-1:0];
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done) begin
                check("busy_done_exclusive", {31'd0, busy}, 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("bin_out", {22'd0, bin_out}, {22'd0, e.bin});
                    check("err", {31'd0, err}, {31'd0, e.err});
                    check("latency", ecount - e.acc, e.err ? 32'd0 : BIN_W);
                    check("busy_cycles", busy_run, e.err ? 32'd0 : BIN_W);
                end
                busy_run = 0;
            end else if (busy) begin
                busy_run = busy_run + 1;
            end else begin
                busy_run = 0;
            end
        end else begin
            busy_run = 0;
        end
    end

    // Wait for an idle cycle, present a request and log its expectation.
    // With keep=1 start stays asserted after the accept.
    task automatic issue(input logic [11:0] b, input bit keep);
        exp_t       e;
        logic [BIN_W-1:0] v;
        logic       er;
        int         t;
        t = 0;
        @(negedge clk);
        while (busy && t < 50) begin
            @(negedge clk);
            t = t + 1;
        end
        if (t >= 50) check("busy_timeout", 32'd1, 32'd0);
        ref_model(b, v, er);
        bcd_in = b;
        start  = 1'b1;
        e.bin = v;
        e.err = er;
        e.acc = ecount + 1;
        sb.push_back(e);
        if (!keep) begin
            @(negedge clk);
            start  = 1'b0;
            bcd_in = $urandom_range(0, 4095);
            if (er) begin
                check("reject_busy", {31'd0, busy}, 32'd0);
                check("reject_err", {31'd0, err}, 32'd1);
                check("reject_bin", {22'd0, bin_out}, 32'd0);
            end else begin
                check("accept_busy", {31'd0, busy}, 32'd1);
                check("accept_err_clear", {31'd0, err}, 32'd0);
            end
        end
    endtask

    initial begin
        int t;
        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = 12'h000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_bin", {22'd0, bin_out}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);

        // Largest three-digit value.
        issue(12'h999, 1'b0);

        // Back-to-back with start held through the first done.
        issue(12'h511, 1'b1);
        issue(12'h000, 1'b0);

        // Invalid digit followed by a valid request.
        issue(12'h9A3, 1'b0);
        issue(12'h042, 1'b0);

        // Start pulse while busy must be ignored.
        issue(12'h250, 1'b0);
        repeat (2) @(negedge clk);
        bcd_in = 12'h777;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;

        // Reset in the middle of a conversion.
        issue(12'h123, 1'b0);
        repeat (3) @(negedge clk);
        sb.delete();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset_bin", {22'd0, bin_out}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_err", {31'd0, err}, 32'd0);
        repeat (15) @(negedge clk);
        issue(12'h123, 1'b0);

        // Exhaustive valid sweep.
        for (int n = 0; n < 1000; n++) begin
            logic [11:0] b;
            b = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
            issue(b, 1'b0);
        end

        // Random packed values, valid and invalid, with occasional held start.
        for (int k = 0; k < 300; k++) begin
            issue(12'($urandom_range(0, 4095)), bit'($urandom_range(0, 1)));
        end
        issue(12'h314, 1'b0);

        // Drain outstanding expectations.
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t = t + 1;
        end
        check("drain", sb.size(), 32'd0);
        repeat (15) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
Sequential BCD-to-binary converter using reverse double-dabble: one shift-right per clock, then a subtract-3 correction on every BCD digit >= 8. It is the inverse of the display-side binary-to-BCD converter. It takes packed decimal values (keypad entry, preset scores/speeds) and returns the plain binary value for game/arithmetic logic. The interface is a start/busy/done handshake, and invalid digits are flagged.

Parameters:
DIGITS, 3, number of packed BCD digits at input (input width 4*DIGITS).
BIN_W, 10, binary output width; must satisfy 2^BIN_W > 10^DIGITS-1 (default covers 0..999). Also the number of shift cycles per conversion.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst_n  input  1  Synchronous reset, active low. Sampled on the rising edge of clk.
start  input  1  request; sampled only in IDLE.
bcd_in  input  4*DIGITS  packed BCD, digit 0 in [3:0]; sampled on the accepting edge only.
bin_out  output  BIN_W  converted result; holds until the next completed conversion.
busy  output  1  high while conversion in progress.
done  output  1  single-cycle completion pulse.
err  output  1  last accepted input had a digit > 9; holds until next accepted start.

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; bin_out=0, busy=0, done=0, err=0; shift regs and counter cleared. Reset overrides everything, including mid-conversion. No done pulse results from an aborted conversion.
- States: IDLE, SHIFT.
- Default every edge: done<=0 unless set below.
- IDLE, start=1 (edge E0), all digits <= 9:
  - Load bcd_reg<=bcd_in, bin_reg<=0, cnt<=0, err<=0, busy<=1, go to SHIFT.
- IDLE, start=1, any digit > 9:
  - Do not convert. At E0: err<=1, done<=1, bin_out<=0, busy stays 0, stay IDLE.
  - done and err are visible in the cycle after E0.
- SHIFT, each edge:
  - Shift the concatenation {bcd_reg,bin_reg} right by 1. bcd_reg[0] enters bin_reg[BIN_W-1].
  - Then, on the shifted bcd_reg, every 4-bit digit >= 8 gets -3 (4-bit, no borrow between digits). Shift and adjust both complete in the same edge.
  - cnt<=cnt+1.
- SHIFT, edge where cnt==BIN_W-1 (the BIN_W-th shift):
  - bin_out<= the shifted bin value, done<=1, busy<=0, go to IDLE.
  - The adjust result on that edge is don't-care.
- Latency: done high in the cycle after edge E0+BIN_W (default: 10 edges after the accepting edge). Throughput is one conversion per BIN_W+1 cycles.
- start while busy: ignored, with no effect on the conversion in flight and no queuing.
- start high in the same cycle done is high: state is IDLE, so it is accepted (back-to-back).
- start held high continuously: a new conversion is accepted every BIN_W+1 cycles.
- bcd_in changes while busy: no effect.
- bin_out changes only on the completion edge or the invalid-input edge. busy and done are never high together.
- cnt width is clog2(BIN_W)+1. No overflow is possible given the parameter constraint.

Test Plan:
- Reset then start with bcd_in=12'h999 -> busy high for 10 cycles; done pulses once in the 11th cycle; bin_out=10'd999 (10'h3E7); err=0.
- bcd_in=12'h511, then bcd_in=12'h000 back-to-back, with start held through the first done -> bin_out=10'd511 (10'h1FF) at the first done; bin_out=0 exactly 11 cycles later; exactly two done pulses.
- bcd_in=12'h9A3 with start -> next cycle: done=1, err=1, bin_out=0, busy never asserts. A following valid 12'h042 -> err clears on the accept edge; bin_out=10'd42.
- During a 12'h250 conversion, pulse start with bcd_in=12'h777 at cycle 4 -> ignored; single done; bin_out=10'd250.
- Assert rst_n=0 for one edge at cycle 5 of a 12'h123 conversion -> next cycle bin_out=0, busy=0, done=0, err=0; no done follows. A new 12'h123 start then completes with bin_out=10'd123.
- Exhaustive sweep of 000..999 with a self-checking model -> every result is exact; done latency is always 10 cycles.
